// File: rtl/common_function_def.sv
// Small arithmetic helpers shared across the transport subsystem.
package common_function_def;

  // Increment modulo 2^w, for sequence counters up to 32 bits wide.
  function automatic logic [31:0] psn_inc(input logic [31:0] psn,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (psn + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/transport_subsystem_def.sv
// Shared transport-subsystem definitions: commit FSM state encodings and
// bit offsets of the metadata word and the find-response word.
package transport_subsystem_def;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EPSN_RD = 3'd1,
    FIND    = 3'd2,
    DELETE  = 3'd3,
    STREAM  = 3'd4,
    EPSN_WR = 3'd5
  } commit_state_t;

  // Metadata word layout is {upper, lower, qpn}, qpn in the low bits.
  localparam int unsigned META_QPN_LSB = 0;

  function automatic int unsigned meta_lower_lsb(input int unsigned qpn_w);
    return qpn_w;
  endfunction

  function automatic int unsigned meta_upper_lsb(input int unsigned qpn_w,
                                                 input int unsigned psn_w);
    return qpn_w + psn_w;
  endfunction

  // Find response is {hit, slot}: the hit flag sits just above the slot.
  function automatic int unsigned find_hit_bit(input int unsigned slot_w);
    return slot_w;
  endfunction

endpackage

// File: rtl/inorder_commit_engine.sv
// Commits buffered packets of a QP strictly in PSN order: pops a metadata range,
// checks it against the expected PSN, then finds/deletes/streams packet by packet.
module inorder_commit_engine
  import transport_subsystem_def::*, common_function_def::*;
#(
  parameter int QPN_W     = 24,
  parameter int PSN_W     = 24,
  parameter int SLOT_W    = 12,
  parameter int HEAD_W    = 256,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 16,
  parameter int HDR_TRIM  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_pkt_meta_empty,
  input  logic [QPN_W+2*PSN_W-1:0]        iv_pkt_meta_dout,
  output logic                            o_pkt_meta_rd_en,
  output logic                            o_find_req_valid,
  output logic [QPN_W+PSN_W-1:0]          ov_find_req_head,
  input  logic                            i_find_resp_valid,
  input  logic [SLOT_W:0]                 iv_find_resp_data,
  output logic                            o_delete_req_valid,
  output logic [SLOT_W+PSN_W+QPN_W-1:0]   ov_delete_req_head,
  input  logic                            i_delete_req_ready,
  input  logic                            i_delete_resp_valid,
  input  logic                            i_delete_resp_start,
  input  logic                            i_delete_resp_last,
  input  logic [HEAD_W-1:0]               iv_delete_resp_head,
  input  logic [DATA_W-1:0]               iv_delete_resp_data,
  output logic                            o_delete_resp_ready,
  output logic [QPN_W-1:0]                ov_epsn_rd_index,
  input  logic [PSN_W-1:0]                iv_epsn_rd_data,
  output logic                            o_epsn_wr_en,
  output logic [QPN_W-1:0]                ov_epsn_wr_index,
  output logic [PSN_W-1:0]                ov_epsn_wr_data,
  output logic                            o_commit_valid,
  output logic                            o_commit_start,
  output logic                            o_commit_last,
  output logic [HEAD_W-1:0]               ov_commit_head,
  output logic [DATA_W-1:0]               ov_commit_data,
  input  logic                            i_commit_ready
);

  localparam int unsigned QPN_LSB   = META_QPN_LSB;
  localparam int unsigned LOWER_LSB = meta_lower_lsb(QPN_W);
  localparam int unsigned UPPER_LSB = meta_upper_lsb(QPN_W, PSN_W);
  localparam int unsigned HIT_BIT   = find_hit_bit(SLOT_W);
  localparam int          CNT_W     = $clog2(MAX_BURST + 1);

  commit_state_t      state_reg;
  logic [QPN_W-1:0]   qpn_reg;
  logic [PSN_W-1:0]   lower_reg;
  logic [PSN_W-1:0]   upper_reg;
  logic [PSN_W-1:0]   cur_psn_reg;
  logic [SLOT_W-1:0]  slot_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               rd_wait_reg;
  logic               find_wait_reg;

  logic               in_stream;
  logic               last_fire;
  logic [PSN_W-1:0]   next_psn;

  assign in_stream = (state_reg == STREAM);
  assign last_fire = in_stream & i_delete_resp_valid & i_delete_resp_last & i_commit_ready;
  assign next_psn  = PSN_W'(psn_inc(32'(cur_psn_reg), PSN_W));

  // The FIFO is first-word-fall-through, so the pop has to coincide with the latch.
  assign o_pkt_meta_rd_en = rst & (state_reg == IDLE) & ~i_pkt_meta_empty;

  assign ov_epsn_rd_index = (state_reg == EPSN_RD) ? qpn_reg : '0;

  assign o_find_req_valid = (state_reg == FIND) & ~find_wait_reg;
  assign ov_find_req_head = o_find_req_valid ? {cur_psn_reg, qpn_reg} : '0;

  assign o_delete_req_valid = (state_reg == DELETE);
  assign ov_delete_req_head = o_delete_req_valid ? {slot_reg, cur_psn_reg, qpn_reg} : '0;

  // Zero-latency pass-through while streaming; backpressure goes straight upstream.
  assign o_commit_valid      = in_stream & i_delete_resp_valid;
  assign o_commit_start      = in_stream & i_delete_resp_start;
  assign o_commit_last       = in_stream & i_delete_resp_last;
  assign ov_commit_data      = in_stream ? iv_delete_resp_data : '0;
  assign o_delete_resp_ready = in_stream & i_commit_ready;
  assign ov_commit_head      = (in_stream & i_delete_resp_start)
                             ? {iv_delete_resp_head[HEAD_W-1:8],
                                iv_delete_resp_head[7:0] - 8'(HDR_TRIM)}
                             : '0;

  assign o_epsn_wr_en     = (state_reg == EPSN_WR);
  assign ov_epsn_wr_index = o_epsn_wr_en ? qpn_reg : '0;
  assign ov_epsn_wr_data  = o_epsn_wr_en ? cur_psn_reg : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      qpn_reg       <= '0;
      lower_reg     <= '0;
      upper_reg     <= '0;
      cur_psn_reg   <= '0;
      slot_reg      <= '0;
      cnt_reg       <= '0;
      rd_wait_reg   <= 1'b0;
      find_wait_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!i_pkt_meta_empty) begin
            qpn_reg     <= iv_pkt_meta_dout[QPN_LSB +: QPN_W];
            lower_reg   <= iv_pkt_meta_dout[LOWER_LSB +: PSN_W];
            upper_reg   <= iv_pkt_meta_dout[UPPER_LSB +: PSN_W];
            cnt_reg     <= '0;
            rd_wait_reg <= 1'b0;
            state_reg   <= EPSN_RD;
          end
        end
        EPSN_RD: begin
          // First cycle presents the index, second cycle consumes the read data.
          if (!rd_wait_reg) begin
            rd_wait_reg <= 1'b1;
          end else begin
            rd_wait_reg <= 1'b0;
            if (iv_epsn_rd_data != lower_reg) begin
              state_reg <= IDLE;
            end else begin
              cur_psn_reg   <= iv_epsn_rd_data;
              find_wait_reg <= 1'b0;
              state_reg     <= FIND;
            end
          end
        end
        FIND: begin
          if (!find_wait_reg) begin
            find_wait_reg <= 1'b1;
          end else if (i_find_resp_valid) begin
            find_wait_reg <= 1'b0;
            if (iv_find_resp_data[HIT_BIT]) begin
              slot_reg  <= iv_find_resp_data[SLOT_W-1:0];
              state_reg <= DELETE;
            end else begin
              state_reg <= EPSN_WR;
            end
          end
        end
        DELETE: begin
          if (i_delete_req_ready) state_reg <= STREAM;
        end
        STREAM: begin
          if (last_fire) begin
            cur_psn_reg <= next_psn;
            cnt_reg     <= cnt_reg + CNT_W'(1);
            if (cur_psn_reg == upper_reg || cnt_reg == CNT_W'(MAX_BURST - 1))
              state_reg <= EPSN_WR;
            else
              state_reg <= FIND;
          end
        end
        EPSN_WR: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inorder_commit_engine.sv
// Scoreboard bench for inorder_commit_engine: a reference model queues the
// expected find/delete/commit/EPSN-write traffic, monitors pop and compare it.
module tb_inorder_commit_engine;

  localparam int QPN_W = 24, PSN_W = 24, SLOT_W = 12;
  localparam int HEAD_W = 256, DATA_W = 256, MAX_BURST = 16, HDR_TRIM = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                          i_pkt_meta_empty;
  logic [QPN_W+2*PSN_W-1:0]      iv_pkt_meta_dout;
  logic                          o_pkt_meta_rd_en;
  logic                          o_find_req_valid;
  logic [QPN_W+PSN_W-1:0]        ov_find_req_head;
  logic                          i_find_resp_valid;
  logic [SLOT_W:0]               iv_find_resp_data;
  logic                          o_delete_req_valid;
  logic [SLOT_W+PSN_W+QPN_W-1:0] ov_delete_req_head;
  logic                          i_delete_req_ready;
  logic                          i_delete_resp_valid, i_delete_resp_start, i_delete_resp_last;
  logic [HEAD_W-1:0]             iv_delete_resp_head;
  logic [DATA_W-1:0]             iv_delete_resp_data;
  logic                          o_delete_resp_ready;
  logic [QPN_W-1:0]              ov_epsn_rd_index;
  logic [PSN_W-1:0]              iv_epsn_rd_data;
  logic                          o_epsn_wr_en;
  logic [QPN_W-1:0]              ov_epsn_wr_index;
  logic [PSN_W-1:0]              ov_epsn_wr_data;
  logic                          o_commit_valid, o_commit_start, o_commit_last;
  logic [HEAD_W-1:0]             ov_commit_head;
  logic [DATA_W-1:0]             ov_commit_data;
  logic                          i_commit_ready;

  inorder_commit_engine #(
    .QPN_W(QPN_W), .PSN_W(PSN_W), .SLOT_W(SLOT_W), .HEAD_W(HEAD_W),
    .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .HDR_TRIM(HDR_TRIM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pkt_meta_empty(i_pkt_meta_empty), .iv_pkt_meta_dout(iv_pkt_meta_dout),
    .o_pkt_meta_rd_en(o_pkt_meta_rd_en),
    .o_find_req_valid(o_find_req_valid), .ov_find_req_head(ov_find_req_head),
    .i_find_resp_valid(i_find_resp_valid), .iv_find_resp_data(iv_find_resp_data),
    .o_delete_req_valid(o_delete_req_valid), .ov_delete_req_head(ov_delete_req_head),
    .i_delete_req_ready(i_delete_req_ready),
    .i_delete_resp_valid(i_delete_resp_valid), .i_delete_resp_start(i_delete_resp_start),
    .i_delete_resp_last(i_delete_resp_last), .iv_delete_resp_head(iv_delete_resp_head),
    .iv_delete_resp_data(iv_delete_resp_data), .o_delete_resp_ready(o_delete_resp_ready),
    .ov_epsn_rd_index(ov_epsn_rd_index), .iv_epsn_rd_data(iv_epsn_rd_data),
    .o_epsn_wr_en(o_epsn_wr_en), .ov_epsn_wr_index(ov_epsn_wr_index),
    .ov_epsn_wr_data(ov_epsn_wr_data),
    .o_commit_valid(o_commit_valid), .o_commit_start(o_commit_start),
    .o_commit_last(o_commit_last), .ov_commit_head(ov_commit_head),
    .ov_commit_data(ov_commit_data), .i_commit_ready(i_commit_ready)
  );

  typedef struct {
    logic [255:0] data;
    logic [255:0] head;
    logic         start;
    logic         last;
  } beat_t;

  logic [71:0] meta_q[$];
  logic [47:0] exp_find[$];
  logic [59:0] exp_del[$];
  logic [47:0] exp_wr[$];
  beat_t       exp_commit[$];
  logic [23:0] pkt_q[$];
  logic [23:0] epsn_mem[logic [23:0]];

  int total = 0, bad = 0;
  int miss_psn = -1, nb = 1;
  bit hold_valid = 1'b0, toggle_ready = 1'b0;
  int finds = 0, dels = 0, commits = 0, wrs = 0, starts = 0, lasts = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] slot_of(input logic [23:0] p);
    return p[11:0] ^ 12'h5A5;
  endfunction

  function automatic logic [7:0] len_of(input logic [23:0] p);
    logic [23:0] t;
    t = p * 24'd7 + 24'd1;
    return t[7:0];
  endfunction

  function automatic logic [255:0] head_in(input logic [23:0] p);
    return {32'hBEEF_0000, 192'd0, p, len_of(p)};
  endfunction

  function automatic logic [255:0] head_exp(input logic [23:0] p);
    return {32'hBEEF_0000, 192'd0, p, 8'(len_of(p) - 8'd3)};
  endfunction

  function automatic logic [255:0] mkdata(input logic [23:0] p, input int b);
    return {32'hDA7A_0000, 184'd0, 8'(b), p, 8'(b)};
  endfunction

  // Reference model: queue the meta entry and everything it should cause.
  task automatic expect_entry(input logic [23:0] qpn, input logic [23:0] lower,
                              input logic [23:0] upper);
    logic [23:0] p, e;
    int n;
    e = epsn_mem.exists(qpn) ? epsn_mem[qpn] : 24'd0;
    meta_q.push_back({upper, lower, qpn});
    if (e != lower) return;
    p = lower;
    n = 0;
    forever begin
      exp_find.push_back({p, qpn});
      if (int'(p) == miss_psn) begin
        exp_wr.push_back({qpn, p});
        break;
      end
      exp_del.push_back({slot_of(p), p, qpn});
      for (int b = 0; b < nb; b++)
        exp_commit.push_back('{mkdata(p, b), (b == 0) ? head_exp(p) : 256'd0,
                               (b == 0), (b == nb - 1)});
      n++;
      if (p == upper || n == MAX_BURST) begin
        exp_wr.push_back({qpn, p + 24'd1});
        break;
      end
      p = p + 24'd1;
    end
  endtask

  // Environment: metadata FIFO, EPSN RAM, find/delete responders, commit sink.
  initial begin
    bit          find_pend = 1'b0, find_hit = 1'b0;
    logic [11:0] find_slot = '0;
    logic [23:0] last_idx = '0;
    int          beat = 0, cyc = 0;
    beat_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      i_pkt_meta_empty  = (meta_q.size() == 0);
      iv_pkt_meta_dout  = (meta_q.size() == 0) ? 72'd0 : meta_q[0];
      iv_epsn_rd_data   = epsn_mem.exists(last_idx) ? epsn_mem[last_idx] : 24'd0;
      i_find_resp_valid = find_pend;
      iv_find_resp_data = find_pend ? {find_hit, find_slot} : 13'd0;
      find_pend         = 1'b0;
      i_delete_req_ready = (cyc % 3 != 1);
      i_commit_ready     = toggle_ready ? (cyc % 2 == 0) : 1'b1;
      if (pkt_q.size() != 0) begin
        i_delete_resp_valid = hold_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
        i_delete_resp_start = (beat == 0);
        i_delete_resp_last  = (beat == nb - 1);
        iv_delete_resp_head = head_in(pkt_q[0]);
        iv_delete_resp_data = mkdata(pkt_q[0], beat);
      end else begin
        i_delete_resp_valid = 1'b0;
        i_delete_resp_start = 1'b0;
        i_delete_resp_last  = 1'b0;
        iv_delete_resp_head = '0;
        iv_delete_resp_data = '0;
      end
      #1;
      last_idx = ov_epsn_rd_index;
      if (o_pkt_meta_rd_en && meta_q.size() != 0) void'(meta_q.pop_front());
      if (o_find_req_valid) begin
        finds++;
        if (exp_find.size() == 0) check("find_unexpected", 1, 0);
        else check("find_req", ov_find_req_head, exp_find.pop_front());
        find_pend = 1'b1;
        find_hit  = (int'(ov_find_req_head[47:24]) != miss_psn);
        find_slot = slot_of(ov_find_req_head[47:24]);
      end
      if (o_delete_req_valid && i_delete_req_ready) begin
        dels++;
        if (exp_del.size() == 0) check("delete_unexpected", 1, 0);
        else check("delete_req", ov_delete_req_head, exp_del.pop_front());
        pkt_q.push_back(ov_delete_req_head[47:24]);
      end
      if (o_commit_valid && i_commit_ready) begin
        commits++;
        if (o_commit_start) starts++;
        if (o_commit_last) lasts++;
        if (exp_commit.size() == 0) check("commit_unexpected", 1, 0);
        else begin
          e = exp_commit.pop_front();
          check("commit_data", ov_commit_data, e.data);
          check("commit_head", ov_commit_head, e.head);
          check("commit_flags", {o_commit_start, o_commit_last}, {e.start, e.last});
        end
      end
      if (i_delete_resp_valid && o_delete_resp_ready && pkt_q.size() != 0) begin
        beat++;
        if (beat == nb) begin
          beat = 0;
          void'(pkt_q.pop_front());
        end
      end
      if (o_epsn_wr_en) begin
        wrs++;
        if (exp_wr.size() == 0) check("epsn_wr_unexpected", 1, 0);
        else check("epsn_wr", {ov_epsn_wr_index, ov_epsn_wr_data}, exp_wr.pop_front());
        epsn_mem[ov_epsn_wr_index] = ov_epsn_wr_data;
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((meta_q.size() != 0 || exp_find.size() != 0 || exp_del.size() != 0 ||
            exp_commit.size() != 0 || exp_wr.size() != 0 || pkt_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check({tag, "_timeout"}, (n >= 4000), 0);
  endtask

  initial begin
    int f0, d0, c0, w0;
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  initial begin
    int f0, d0, c0, w0;
    // Stale entry present during reset: it must not be popped until reset releases.
    epsn_mem[24'd1] = 24'd0;
    expect_entry(24'd1, 24'd5, 24'd5);
    repeat (4) @(negedge clk);
    #2;
    check("rst_rd_en", o_pkt_meta_rd_en, 0);
    check("rst_find_valid", o_find_req_valid, 0);
    check("rst_delete_valid", o_delete_req_valid, 0);
    check("rst_commit_valid", o_commit_valid, 0);
    check("rst_epsn_wr", o_epsn_wr_en, 0);
    check("rst_epsn_idx", ov_epsn_rd_index, 0);
    check("rst_meta_kept", meta_q.size(), 1);
    @(negedge clk);
    rst = 1'b1;
    wait_drain("stale_boot");

    // Three hits, then bounded by upper.
    epsn_mem[24'd7] = 24'd3;
    c0 = commits; d0 = dels;
    expect_entry(24'd7, 24'd3, 24'd5);
    wait_drain("basic");
    check("basic_epsn", epsn_mem[24'd7], 24'd6);
    check("basic_commits", commits - c0, 3);
    check("basic_deletes", dels - d0, 3);

    // Hole at PSN 4.
    epsn_mem[24'd7] = 24'd3;
    miss_psn = 4;
    c0 = commits; d0 = dels;
    expect_entry(24'd7, 24'd3, 24'd5);
    wait_drain("hole");
    check("hole_epsn", epsn_mem[24'd7], 24'd4);
    check("hole_commits", commits - c0, 1);
    check("hole_deletes", dels - d0, 1);
    miss_psn = -1;

    // Stale entry: popped, nothing else happens.
    epsn_mem[24'd7] = 24'd6;
    f0 = finds; d0 = dels; c0 = commits; w0 = wrs;
    expect_entry(24'd7, 24'd3, 24'd5);
    wait_drain("stale");
    check("stale_meta_popped", meta_q.size(), 0);
    check("stale_activity", {32'(finds - f0), 32'(dels - d0), 32'(commits - c0), 32'(wrs - w0)}, 0);
    check("stale_epsn", epsn_mem[24'd7], 24'd6);

    // PSN wrap across 2^24-1 -> 0.
    epsn_mem[24'd9] = 24'hFFFFFE;
    c0 = commits;
    expect_entry(24'd9, 24'hFFFFFE, 24'h000001);
    wait_drain("wrap");
    check("wrap_epsn", epsn_mem[24'd9], 24'h000002);
    check("wrap_commits", commits - c0, 4);

    // Burst limit, then a follow-up entry picks up the rest.
    epsn_mem[24'd12] = 24'd10;
    c0 = commits;
    expect_entry(24'd12, 24'd10, 24'd40);
    wait_drain("burst");
    check("burst_epsn", epsn_mem[24'd12], 24'd26);
    check("burst_commits", commits - c0, MAX_BURST);
    c0 = commits;
    expect_entry(24'd12, 24'd26, 24'd40);
    wait_drain("burst_rest");
    check("burst_rest_epsn", epsn_mem[24'd12], 24'd41);
    check("burst_rest_commits", commits - c0, 15);

    // Four-beat packet with commit backpressure every other cycle.
    nb = 4; hold_valid = 1'b1; toggle_ready = 1'b1;
    epsn_mem[24'd3] = 24'd50;
    c0 = commits; f0 = starts; w0 = lasts;
    expect_entry(24'd3, 24'd50, 24'd50);
    wait_drain("bp");
    check("bp_beats", commits - c0, 4);
    check("bp_starts", starts - f0, 1);
    check("bp_lasts", lasts - w0, 1);
    check("bp_epsn", epsn_mem[24'd3], 24'd51);
    nb = 1; hold_valid = 1'b0; toggle_ready = 1'b0;

    #2;
    check("idle_commit_head", ov_commit_head, 0);
    check("idle_delete_head", ov_delete_req_head, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
